// File: rtl/pipelined_tree_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_tree_multiplier
//  Brief    : Three-stage WIDTH x WIDTH multiplier. Baugh-Wooley partial
//             products are compressed by an FA/HA tree and summed with a
//             Sklansky prefix adder. Each stage has a valid/ready handshake.
//  Revision : 1.0  initial pipelined release
// ============================================================================
module pipelined_tree_multiplier #(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]   y,
   input  logic               signed_mode,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] o,
   output logic [TAG_W-1:0]   out_tag
);

   localparam int PW   = 2 * WIDTH;     // product width
   localparam int MAXH = WIDTH + 2;     // headroom for the tallest column
   localparam int NLVL = 12;            // enough Wallace levels for WIDTH<=32
   localparam int LV   = $clog2(PW);    // prefix-adder levels

   typedef logic [MAXH-1:0] col_t;

   // Bit k of a column, read via shift so the index can be data-sized.
   function automatic logic col_bit(input col_t v, input int k);
      col_t t;
      t = v >> k;
      return t[0];
   endfunction

   function automatic logic row_bit(input logic [PW-1:0] v, input int k);
      logic [PW-1:0] t;
      t = v >> k;
      return t[0];
   endfunction

   // Builds the partial-product matrix and compresses it to two rows.
   // Returns {carry_row, sum_row}.
   function automatic logic [2*PW-1:0] csa_rows(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic             sm);
      col_t         m  [PW];
      col_t         nm [PW];
      int           h  [PW];
      int           nh [PW];
      int           hmax;
      int           cn;
      logic         pb, b0, b1, b2, s, cy;
      logic [PW-1:0] s_row, c_row;
      hmax = 0; cn = 0;
      pb = 1'b0; b0 = 1'b0; b1 = 1'b0; b2 = 1'b0; s = 1'b0; cy = 1'b0;
      s_row = '0; c_row = '0;
      for (int c = 0; c < PW; c++) begin
         m[c] = '0; h[c] = 0; nm[c] = '0; nh[c] = 0;
      end
      // Baugh-Wooley: cross terms touching exactly one operand MSB are
      // inverted in signed mode; the MSB*MSB term stays positive.
      for (int i = 0; i < WIDTH; i++) begin
         for (int j = 0; j < WIDTH; j++) begin
            pb = a[j] & b[i];
            if (sm && ((i == WIDTH-1) != (j == WIDTH-1)))
               pb = ~pb;
            m[i+j] = m[i+j] | ({{(MAXH-1){1'b0}}, pb} << h[i+j]);
            h[i+j] = h[i+j] + 1;
         end
      end
      // Correction constants at columns WIDTH and 2*WIDTH-1 (signed only).
      m[WIDTH] = m[WIDTH] | ({{(MAXH-1){1'b0}}, sm} << h[WIDTH]);
      h[WIDTH] = h[WIDTH] + 1;
      m[PW-1]  = m[PW-1] | ({{(MAXH-1){1'b0}}, sm} << h[PW-1]);
      h[PW-1]  = h[PW-1] + 1;
      // Wallace levels: triples go to FAs, a leftover pair to an HA, until
      // every column holds at most two bits. Carries out of the top column
      // are dropped (result is modulo 2^PW).
      for (int lv = 0; lv < NLVL; lv++) begin
         hmax = 0;
         for (int c = 0; c < PW; c++)
            if (h[c] > hmax) hmax = h[c];
         if (hmax > 2) begin
            for (int c = 0; c < PW; c++) begin
               nm[c] = '0; nh[c] = 0;
            end
            for (int c = 0; c < PW; c++) begin
               cn = (c + 1 < PW) ? c + 1 : c;
               for (int k = 0; k < MAXH; k += 3) begin
                  if (k + 2 < h[c]) begin
                     b0 = col_bit(m[c], k);
                     b1 = col_bit(m[c], k + 1);
                     b2 = col_bit(m[c], k + 2);
                     s  = b0 ^ b1 ^ b2;
                     cy = (b0 & b1) | (b0 & b2) | (b1 & b2);
                     nm[c] = nm[c] | ({{(MAXH-1){1'b0}}, s} << nh[c]);
                     nh[c] = nh[c] + 1;
                     if (c + 1 < PW) begin
                        nm[cn] = nm[cn] | ({{(MAXH-1){1'b0}}, cy} << nh[cn]);
                        nh[cn] = nh[cn] + 1;
                     end
                  end else if (k + 1 < h[c]) begin
                     b0 = col_bit(m[c], k);
                     b1 = col_bit(m[c], k + 1);
                     s  = b0 ^ b1;
                     cy = b0 & b1;
                     nm[c] = nm[c] | ({{(MAXH-1){1'b0}}, s} << nh[c]);
                     nh[c] = nh[c] + 1;
                     if (c + 1 < PW) begin
                        nm[cn] = nm[cn] | ({{(MAXH-1){1'b0}}, cy} << nh[cn]);
                        nh[cn] = nh[cn] + 1;
                     end
                  end else if (k < h[c]) begin
                     b0 = col_bit(m[c], k);
                     nm[c] = nm[c] | ({{(MAXH-1){1'b0}}, b0} << nh[c]);
                     nh[c] = nh[c] + 1;
                  end
               end
            end
            for (int c = 0; c < PW; c++) begin
               m[c] = nm[c]; h[c] = nh[c];
            end
         end
      end
      for (int c = 0; c < PW; c++) begin
         s_row[c] = col_bit(m[c], 0);
         c_row[c] = col_bit(m[c], 1);
      end
      return {c_row, s_row};
   endfunction

   // Sklansky prefix adder. Each node at level l merges with the top of the
   // lower half of its 2^(l+1) block; group-propagate is computed at every
   // node (black cell) even where only generate is needed (grey cell).
   function automatic logic [PW-1:0] prefix_add(input logic [PW-1:0] a,
                                                input logic [PW-1:0] b);
      logic [PW-1:0] p, gg, pg, gn, pn;
      int            j;
      p  = a ^ b;
      gg = a & b;
      pg = p;
      gn = gg;
      pn = pg;
      j  = 0;
      for (int l = 0; l < LV; l++) begin
         gn = gg;
         pn = pg;
         for (int i = 0; i < PW; i++) begin
            if (((i >> l) & 1) == 1) begin
               j     = ((i >> l) << l) - 1;
               gn[i] = gg[i] | (pg[i] & row_bit(gg, j));
               pn[i] = pg[i] & row_bit(pg, j);
            end
         end
         gg = gn;
         pg = pn;
      end
      return p ^ {gg[PW-2:0], 1'b0};
   endfunction

   // Stage registers
   logic               s1_valid;
   logic [WIDTH-1:0]   s1_x;
   logic [WIDTH-1:0]   s1_y;
   logic               s1_signed;
   logic [TAG_W-1:0]   s1_tag;
   logic               s2_valid;
   logic [PW-1:0]      s2_sum;
   logic [PW-1:0]      s2_carry;
   logic [TAG_W-1:0]   s2_tag;

   logic               adv1, adv2, adv3;
   logic [2*PW-1:0]    tree_rows;
   logic [PW-1:0]      final_sum;

   // Handshake: a stage loads when empty or when its contents move on.
   always_comb begin
      adv3     = out_valid && out_ready;
      adv2     = s2_valid && (!out_valid || adv3);
      adv1     = s1_valid && (!s2_valid || adv2);
      in_ready = !s1_valid || adv1;
   end

   // Combinational datapath between registered stages.
   always_comb begin
      tree_rows = csa_rows(s1_x, s1_y, s1_signed);
      final_sum = prefix_add(s2_sum, s2_carry);
   end

   // Stage 1: capture operands on acceptance.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_x      <= '0;
         s1_y      <= '0;
         s1_signed <= 1'b0;
         s1_tag    <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_x      <= x;
            s1_y      <= y;
            s1_signed <= signed_mode;
            s1_tag    <= in_tag;
         end
      end
   end

   // Stage 2: capture the two carry-save rows from the compression tree.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_sum   <= '0;
         s2_carry <= '0;
         s2_tag   <= '0;
      end else if (!s2_valid || adv2) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_sum   <= tree_rows[PW-1:0];
            s2_carry <= tree_rows[2*PW-1:PW];
            s2_tag   <= s1_tag;
         end
      end
   end

   // Stage 3: final product; held while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         o         <= '0;
         out_tag   <= '0;
      end else if (!out_valid || adv3) begin
         out_valid <= s2_valid;
         if (s2_valid) begin
            o       <= final_sum;
            out_tag <= s2_tag;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_tree_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_tree_multiplier
//  Brief    : Self-checking bench for pipelined_tree_multiplier (WIDTH 8 and 4)
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipelined_tree_multiplier;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // WIDTH=8 instance signals
   logic        in_valid8 = 1'b0, in_ready8, sm8 = 1'b0, out_valid8, out_ready8 = 1'b1;
   logic [7:0]  x8 = '0, y8 = '0;
   logic [3:0]  tag8 = '0, out_tag8;
   logic [15:0] o8;
   // WIDTH=4 instance signals
   logic        in_valid4 = 1'b0, in_ready4, sm4 = 1'b0, out_valid4, out_ready4 = 1'b1;
   logic [3:0]  x4 = '0, y4 = '0;
   logic [3:0]  tag4 = '0, out_tag4;
   logic [7:0]  o4;

   pipelined_tree_multiplier #(.WIDTH(8), .TAG_W(4)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .x(x8), .y(y8), .signed_mode(sm8), .in_tag(tag8),
      .out_valid(out_valid8), .out_ready(out_ready8), .o(o8), .out_tag(out_tag8));

   pipelined_tree_multiplier #(.WIDTH(4), .TAG_W(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
      .x(x4), .y(y4), .signed_mode(sm4), .in_tag(tag4),
      .out_valid(out_valid4), .out_ready(out_ready4), .o(o4), .out_tag(out_tag4));

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [15:0] o;
      logic [3:0]  tag;
   } exp_t;

   exp_t q8[$];
   exp_t q4[$];

   // Reference: true integer product of the operands, reduced mod 2^(2w).
   function automatic logic [15:0] ref_mul(input int w, input logic [31:0] a,
                                           input logic [31:0] b, input logic sm);
      longint sa, sb, p;
      sa = longint'(a);
      sb = longint'(b);
      if (sm && a[w-1]) sa = sa - (longint'(1) << w);
      if (sm && b[w-1]) sb = sb - (longint'(1) << w);
      p = sa * sb;
      return 16'(p & ((longint'(1) << (2*w)) - 1));
   endfunction

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid8); end
      checks++; if (o8 !== 16'h0)        begin errors++; $display("FAIL reset_o: got %h want 0000", o8); end
      checks++; if (out_tag8 !== 4'h0)   begin errors++; $display("FAIL reset_out_tag: got %h want 0", out_tag8); end
      checks++; if (in_ready8 !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready8); end
      checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL reset_out_valid4: got %b want 0", out_valid4); end
   endtask

   // One op into an empty pipeline: latency, value, tag, single emission.
   task automatic test_single_op(input string name, input logic [7:0] a, input logic [7:0] b,
                                 input logic sm, input logic [3:0] tg, input logic [15:0] want);
      @(negedge clk);
      out_ready8 = 1'b1;
      x8 = a; y8 = b; sm8 = sm; tag8 = tg; in_valid8 = 1'b1;
      #1;
      checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL %s_in_ready: got %b want 1", name, in_ready8); end
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         in_valid8 = 1'b0;
         x8 = 8'($urandom); y8 = 8'($urandom); sm8 = 1'($urandom); tag8 = 4'($urandom);
         if (c == 3) begin
            checks++; if (out_valid8 !== 1'b1) begin errors++; $display("FAIL %s_latency: out_valid=%b at cycle 3, want 1", name, out_valid8); end
            checks++; if (o8 !== want) begin errors++; $display("FAIL %s_o: got %h want %h", name, o8, want); end
            checks++; if (out_tag8 !== tg) begin errors++; $display("FAIL %s_tag: got %0d want %0d", name, out_tag8, tg); end
         end else begin
            checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL %s_valid_c%0d: got %b want 0", name, c, out_valid8); end
         end
      end
   endtask

   task automatic test_back_to_back;
      exp_t e;
      int   nres = 0, first = -1, last = -1;
      logic [7:0] a, b;
      logic sm;
      q8.delete();
      for (int cyc = 0; cyc < 40 && nres < 10; cyc++) begin
         @(negedge clk);
         out_ready8 = 1'b1;
         if (out_valid8) begin
            checks++;
            if (q8.size() == 0) begin
               errors++; $display("FAIL b2b_extra: unexpected result o=%h tag=%0d", o8, out_tag8);
            end else begin
               e = q8.pop_front();
               if (o8 !== e.o || out_tag8 !== e.tag) begin
                  errors++; $display("FAIL b2b_result: got o=%h tag=%0d want o=%h tag=%0d", o8, out_tag8, e.o, e.tag);
               end
            end
            if (first < 0) first = cyc;
            last = cyc;
            nres++;
         end
         if (cyc < 10) begin
            a = 8'($urandom); b = 8'($urandom); sm = 1'($urandom);
            x8 = a; y8 = b; sm8 = sm; tag8 = 4'(cyc); in_valid8 = 1'b1;
            #1;
            checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b want 1 at cycle %0d", in_ready8, cyc); end
            if (in_ready8) q8.push_back('{o: ref_mul(8, 32'(a), 32'(b), sm), tag: 4'(cyc)});
         end else begin
            in_valid8 = 1'b0;
         end
      end
      checks++; if (nres !== 10) begin errors++; $display("FAIL b2b_count: got %0d results want 10", nres); end
      checks++; if (last - first !== 9) begin errors++; $display("FAIL b2b_spacing: results spread over %0d cycles want 9", last - first); end
   endtask

   task automatic test_backpressure;
      exp_t e;
      logic [7:0] pa [5];
      logic [7:0] pb [5];
      logic       ps [5];
      logic [15:0] held_o = '0;
      logic [3:0]  held_tag = '0;
      bit   held = 0;
      int   acc = 0, nres = 0;
      q8.delete();
      for (int k = 0; k < 5; k++) begin
         pa[k] = 8'($urandom); pb[k] = 8'($urandom); ps[k] = 1'($urandom);
      end
      for (int cyc = 0; cyc < 8; cyc++) begin
         @(negedge clk);
         out_ready8 = 1'b0;
         if (out_valid8) begin
            if (!held) begin
               held_o = o8; held_tag = out_tag8; held = 1;
            end else begin
               checks++;
               if (o8 !== held_o || out_tag8 !== held_tag) begin
                  errors++; $display("FAIL bp_stall_stable: got o=%h tag=%0d want o=%h tag=%0d", o8, out_tag8, held_o, held_tag);
               end
            end
         end
         if (acc < 5) begin
            x8 = pa[acc]; y8 = pb[acc]; sm8 = ps[acc]; tag8 = 4'(acc + 8); in_valid8 = 1'b1;
            #1;
            if (in_ready8) begin
               q8.push_back('{o: ref_mul(8, 32'(pa[acc]), 32'(pb[acc]), ps[acc]), tag: 4'(acc + 8)});
               acc++;
            end
         end
      end
      checks++; if (acc !== 3) begin errors++; $display("FAIL bp_accepted: got %0d want 3", acc); end
      checks++; if (in_ready8 !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready8); end
      checks++; if (out_valid8 !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b want 1", out_valid8); end
      for (int cyc = 0; cyc < 40 && nres < 5; cyc++) begin
         @(negedge clk);
         out_ready8 = 1'b1;
         if (out_valid8) begin
            checks++;
            if (q8.size() == 0) begin
               errors++; $display("FAIL bp_extra: unexpected result o=%h tag=%0d", o8, out_tag8);
            end else begin
               e = q8.pop_front();
               if (o8 !== e.o || out_tag8 !== e.tag) begin
                  errors++; $display("FAIL bp_drain: got o=%h tag=%0d want o=%h tag=%0d", o8, out_tag8, e.o, e.tag);
               end
            end
            nres++;
         end
         if (acc < 5) begin
            x8 = pa[acc]; y8 = pb[acc]; sm8 = ps[acc]; tag8 = 4'(acc + 8); in_valid8 = 1'b1;
            #1;
            if (in_ready8) begin
               q8.push_back('{o: ref_mul(8, 32'(pa[acc]), 32'(pb[acc]), ps[acc]), tag: 4'(acc + 8)});
               acc++;
            end
         end else begin
            in_valid8 = 1'b0;
         end
      end
      checks++; if (nres !== 5) begin errors++; $display("FAIL bp_drain_count: got %0d want 5", nres); end
      checks++; if (acc !== 5) begin errors++; $display("FAIL bp_total_accepted: got %0d want 5", acc); end
   endtask

   task automatic test_reset_midflight;
      @(negedge clk);
      out_ready8 = 1'b1;
      x8 = 8'd200; y8 = 8'd199; sm8 = 1'b0; tag8 = 4'd1; in_valid8 = 1'b1;
      @(negedge clk);
      x8 = 8'd77; y8 = 8'd3; tag8 = 4'd2;
      @(negedge clk);
      in_valid8 = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid8); end
      checks++; if (o8 !== 16'h0) begin errors++; $display("FAIL rstmid_o: got %h want 0000", o8); end
      checks++; if (out_tag8 !== 4'h0) begin errors++; $display("FAIL rstmid_tag: got %0d want 0", out_tag8); end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL rstmid_ghost: out_valid=%b o=%h cycle %0d want no result", out_valid8, o8, c); end
      end
   endtask

   // Random valid/ready traffic on the 8-bit instance.
   task automatic test_random8;
      exp_t e;
      int   sent = 0, nres = 0;
      logic [7:0] a, b;
      logic sm;
      q8.delete();
      for (int cyc = 0; cyc < 3000 && nres < 200; cyc++) begin
         @(negedge clk);
         out_ready8 = ($urandom_range(0, 9) < 7);
         if (out_valid8 && out_ready8) begin
            checks++;
            if (q8.size() == 0) begin
               errors++; $display("FAIL rand8_extra: unexpected result o=%h", o8);
            end else begin
               e = q8.pop_front();
               if (o8 !== e.o || out_tag8 !== e.tag) begin
                  errors++; $display("FAIL rand8_result: got o=%h tag=%0d want o=%h tag=%0d", o8, out_tag8, e.o, e.tag);
               end
            end
            nres++;
         end
         if (sent < 200 && $urandom_range(0, 9) < 7) begin
            a = 8'($urandom); b = 8'($urandom); sm = 1'($urandom);
            x8 = a; y8 = b; sm8 = sm; tag8 = 4'(sent); in_valid8 = 1'b1;
            #1;
            if (in_ready8) begin
               q8.push_back('{o: ref_mul(8, 32'(a), 32'(b), sm), tag: 4'(sent)});
               sent++;
            end
         end else begin
            in_valid8 = 1'b0;
            x8 = 8'($urandom); y8 = 8'($urandom);
         end
      end
      in_valid8 = 1'b0;
      checks++; if (nres !== 200) begin errors++; $display("FAIL rand8_count: got %0d want 200", nres); end
   endtask

   // Every operand pair in both modes on the 4-bit instance.
   task automatic test_exhaustive_w4;
      exp_t e;
      int   k = 0, nres = 0;
      logic [8:0] kv;
      q4.delete();
      for (int cyc = 0; cyc < 5000 && nres < 512; cyc++) begin
         @(negedge clk);
         out_ready4 = ($urandom_range(0, 3) != 0);
         if (out_valid4 && out_ready4) begin
            checks++;
            if (q4.size() == 0) begin
               errors++; $display("FAIL w4_extra: unexpected result o=%h", o4);
            end else begin
               e = q4.pop_front();
               if (o4 !== e.o[7:0] || out_tag4 !== e.tag) begin
                  errors++; $display("FAIL w4_result: got o=%h tag=%0d want o=%h tag=%0d", o4, out_tag4, e.o[7:0], e.tag);
               end
            end
            nres++;
         end
         if (k < 512) begin
            kv = 9'(k);
            x4 = kv[3:0]; y4 = kv[7:4]; sm4 = kv[8]; tag4 = kv[3:0]; in_valid4 = 1'b1;
            #1;
            if (in_ready4) begin
               q4.push_back('{o: ref_mul(4, 32'(kv[3:0]), 32'(kv[7:4]), kv[8]), tag: kv[3:0]});
               k++;
            end
         end else begin
            in_valid4 = 1'b0;
         end
      end
      in_valid4 = 1'b0;
      checks++; if (nres !== 512) begin errors++; $display("FAIL w4_count: got %0d want 512", nres); end
   endtask

   initial begin
      test_reset();
      test_single_op("u_ff_ff", 8'hFF, 8'hFF, 1'b0, 4'd5, 16'hFE01);
      test_single_op("s_80_80", 8'h80, 8'h80, 1'b1, 4'd6, 16'h4000);
      test_single_op("s_ff_01", 8'hFF, 8'h01, 1'b1, 4'd7, 16'hFFFF);
      test_single_op("s_7f_80", 8'h7F, 8'h80, 1'b1, 4'd8, 16'hC080);
      test_single_op("u_80_80", 8'h80, 8'h80, 1'b0, 4'd9, 16'h4000);
      test_back_to_back();
      test_backpressure();
      test_reset_midflight();
      test_random8();
      test_exhaustive_w4();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
`default_nettype wire
